// File: rtl/scmi_doorbell_arbiter.sv
// Round-robin arbiter for SCMI mailbox doorbells onto the single platform IRQ,
// with completion interrupts per agent channel and a grant watchdog.
module scmi_doorbell_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] doorbell_i,
  input  logic [NUM_CH-1:0] comp_en_i,
  output logic [NUM_CH-1:0] doorbell_clr_o,
  output logic              irq_platform_o,
  output logic [CH_W-1:0]   active_ch_o,
  input  logic              done_i,
  output logic [NUM_CH-1:0] irq_agent_o,
  input  logic [NUM_CH-1:0] irq_agent_ack_i,
  output logic              timeout_o,
  output logic [NUM_CH-1:0] err_ch_o
);

  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WD_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, NOTIFY, COMPLETE} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   active_q, active_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [NUM_CH-1:0] clr_q, clr_d;
  logic [NUM_CH-1:0] irq_agent_q, irq_agent_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              timeout_q, timeout_d;

  logic              any_db;
  logic              found;
  logic [CH_W-1:0]   pick;
  logic              expire;
  int                idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      rr_q        <= '0;
      wdog_q      <= '0;
      clr_q       <= '0;
      irq_agent_q <= '0;
      err_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      rr_q        <= rr_d;
      wdog_q      <= wdog_d;
      clr_q       <= clr_d;
      irq_agent_q <= irq_agent_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  // First requesting channel at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!found && doorbell_i[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  assign any_db = |doorbell_i;
  assign expire = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_W'(WD_MAX));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (any_db) state_d = NOTIFY;
      NOTIFY: begin
        if (done_i)      state_d = COMPLETE;
        else if (expire) state_d = IDLE;
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    active_d    = active_q;
    rr_d        = rr_q;
    wdog_d      = '0;
    clr_d       = '0;
    timeout_d   = 1'b0;
    err_d       = err_q;
    // A same-cycle set below overrides the ack.
    irq_agent_d = irq_agent_q & ~irq_agent_ack_i;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          active_d    = pick;
          rr_d        = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
          clr_d[pick] = 1'b1;
        end
      end
      NOTIFY: begin
        if (TIMEOUT_CYCLES != 0 && !expire) wdog_d = wdog_q + 1'b1;
        else                                wdog_d = wdog_q;
        if (!done_i && expire) begin
          timeout_d       = 1'b1;
          err_d[active_q] = 1'b1;
        end
      end
      COMPLETE: begin
        if (comp_en_i[active_q]) irq_agent_d[active_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign irq_platform_o = (state_q == NOTIFY);
  assign active_ch_o    = active_q;
  assign doorbell_clr_o = clr_q;
  assign irq_agent_o    = irq_agent_q;
  assign timeout_o      = timeout_q;
  assign err_ch_o       = err_q;

endmodule

// File: tb/tb_scmi_doorbell_arbiter.sv
// Directed bench for scmi_doorbell_arbiter (NUM_CH=4, TIMEOUT_CYCLES=8).
module tb_scmi_doorbell_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] doorbell_i, comp_en_i, irq_agent_ack_i;
  logic       done_i;
  logic [3:0] doorbell_clr_o, irq_agent_o, err_ch_o;
  logic       irq_platform_o, timeout_o;
  logic [1:0] active_ch_o;

  int n_chk = 0;
  int n_ok  = 0;

  scmi_doorbell_arbiter #(.NUM_CH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .doorbell_i(doorbell_i), .comp_en_i(comp_en_i),
    .doorbell_clr_o(doorbell_clr_o), .irq_platform_o(irq_platform_o),
    .active_ch_o(active_ch_o), .done_i(done_i), .irq_agent_o(irq_agent_o),
    .irq_agent_ack_i(irq_agent_ack_i), .timeout_o(timeout_o), .err_ch_o(err_ch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs and outputs settle 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irq"}, irq_platform_o, 0);
    chk({tag, "_clr"}, doorbell_clr_o, 0);
    chk({tag, "_act"}, active_ch_o, 0);
    chk({tag, "_agent"}, irq_agent_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
    chk({tag, "_err"}, err_ch_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst_i = 1'b1; doorbell_i = '0; comp_en_i = '0; irq_agent_ack_i = '0; done_i = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst_i = 1'b0;

    // Single request on channel 2
    comp_en_i = 4'b1111; doorbell_i = 4'b0100;
    step();
    chk("single_irq", irq_platform_o, 1);
    chk("single_act", active_ch_o, 2);
    chk("single_clr", doorbell_clr_o, 4'b0100);
    doorbell_i = '0;
    step();
    chk("single_clr_once", doorbell_clr_o, 0);
    chk("single_irq_hold", irq_platform_o, 1);
    step(2);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("single_comp_irq", irq_platform_o, 0);
    chk("single_agent_early", irq_agent_o, 0);
    step();
    chk("single_agent", irq_agent_o, 4'b0100);
    irq_agent_ack_i = 4'b0100;
    step();
    irq_agent_ack_i = '0;
    chk("single_ack", irq_agent_o, 0);
    chk("single_tmo", timeout_o, 0);

    // Round-robin with all doorbells held
    do_reset();
    doorbell_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_irq", k), irq_platform_o, 1);
      chk($sformatf("rr%0d_act", k), active_ch_o, rr_exp[k]);
      chk($sformatf("rr%0d_clr", k), doorbell_clr_o, 32'(4'b0001 << rr_exp[k]));
      done_i = 1'b1;
      if (k == 4) doorbell_i = '0;
      step();
      done_i = 1'b0;
      step();
    end
    chk("rr_agent", irq_agent_o, 4'b1111);
    irq_agent_ack_i = 4'b1111;
    step();
    irq_agent_ack_i = '0;
    chk("rr_ack", irq_agent_o, 0);

    // Watchdog abort on channel 1 (rr pointer is 1 here)
    doorbell_i = 4'b0010;
    step();
    chk("tmo_act", active_ch_o, 1);
    doorbell_i = '0;
    step(7);
    chk("tmo_irq_last", irq_platform_o, 1);
    chk("tmo_not_yet", timeout_o, 0);
    step();
    chk("tmo_pulse", timeout_o, 1);
    chk("tmo_irq_drop", irq_platform_o, 0);
    chk("tmo_err", err_ch_o, 4'b0010);
    chk("tmo_agent", irq_agent_o, 0);
    step();
    chk("tmo_pulse_end", timeout_o, 0);
    chk("tmo_err_sticky", err_ch_o, 4'b0010);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    chk("idle_done_agent", irq_agent_o, 0);
    chk("idle_done_irq", irq_platform_o, 0);

    // done_i on the watchdog's final cycle wins
    do_reset();
    chk("race_err_rst", err_ch_o, 0);
    doorbell_i = 4'b1000;
    step();
    chk("race_act", active_ch_o, 3);
    doorbell_i = '0;
    step(7);
    chk("race_irq", irq_platform_o, 1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("race_tmo", timeout_o, 0);
    chk("race_irq_drop", irq_platform_o, 0);
    step();
    chk("race_agent", irq_agent_o, 4'b1000);
    chk("race_err", err_ch_o, 0);
    chk("race_tmo2", timeout_o, 0);
    irq_agent_ack_i = 4'b1000;
    step();
    irq_agent_ack_i = '0;

    // Completion enable off for channel 3
    comp_en_i = 4'b0111; doorbell_i = 4'b1000;
    step();
    chk("en_off_act", active_ch_o, 3);
    doorbell_i = '0; done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    chk("en_off_agent", irq_agent_o, 0);

    // Enable on, ack collides with the set in the COMPLETE cycle
    comp_en_i = 4'b1111; doorbell_i = 4'b1000;
    step();
    doorbell_i = '0; done_i = 1'b1;
    step();
    done_i = 1'b0; irq_agent_ack_i = 4'b1000;
    step();
    irq_agent_ack_i = '0;
    chk("collide_agent", irq_agent_o, 4'b1000);
    step();
    chk("collide_sticky", irq_agent_o, 4'b1000);
    irq_agent_ack_i = 4'b1000;
    step();
    irq_agent_ack_i = '0;
    chk("collide_ack", irq_agent_o, 0);

    // Reset mid-NOTIFY: rr pointer moved to 3, reset sends it back to 0
    doorbell_i = 4'b0010;
    step();
    chk("pre_rst_act1", active_ch_o, 1);
    doorbell_i = '0; done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    chk("pre_rst_agent", irq_agent_o, 4'b0010);
    doorbell_i = 4'b0100;
    step();
    chk("pre_rst_act2", active_ch_o, 2);
    doorbell_i = 4'b1100;
    step();
    do_reset();
    chk_all_zero("midrst");
    step();
    chk("midrst_irq", irq_platform_o, 1);
    chk("midrst_act", active_ch_o, 2);
    chk("midrst_clr", doorbell_clr_o, 4'b0100);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
